regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the in-order RV64 pipeline; successor to the single-write-port WB-stage register array.
- Adds NR read ports, NW write ports, write-to-read bypass, and a per-register outstanding-write scoreboard.
- Decode uses it to detect RAW/WAW hazards. WB/commit lanes drive the write ports.
- Register x0 reads as zero and is never scoreboarded.

Parameters:
XLEN, 64, register width in bits
NREGS, 32, number of architectural registers (power of 2)
AW, 5, address width, log2(NREGS)
NR, 2, number of read ports
NW, 2, number of write ports; a higher index has higher data priority
CNTW, 2, width of the per-register outstanding-write counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_addr  in  NR*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NR*XLEN  read data, combinational, bypassed
rd_busy  out  NR  read register still has outstanding writes after this cycle's writes
issue_valid  in  1  decode requests to reserve destination issue_rd
issue_rd  in  AW  destination register to reserve
issue_ready  out  1  reservation accepted this cycle
wr_en  in  NW  write-port enables
wr_addr  in  NW*AW  write addresses
wr_data  in  NW*XLEN  write data
flush  in  1  pipeline flush; drops all outstanding reservations

Behaviour:
- Storage: array rf[NREGS] of XLEN bits, plus cnt[NREGS] of CNTW bits.
- Reset: every rf entry is 0 and every cnt is 0 on the edge after rst is sampled high. During rst:
  - issue_ready = 0.
  - rd_busy = 0.
  - rd_data = array contents, which are 0 after the first reset edge.
- Write hit: port j hits address a when wr_en[j] && wr_addr[j]==a && a!=0.
  - hits(a) is the number of ports that hit a in the cycle.
  - The winning data is from the highest-index hitting port.
- Write commit: on each clk edge, rf[a] takes the winning data for every a with hits(a)>0. Writes to x0 are dropped.
- Read:
  - rd_data[i] = 0 if rd_addr[i]==0.
  - Otherwise it is the winning write data if hits(rd_addr[i])>0, else rf[rd_addr[i]].
  - Bypass is zero-latency and purely combinational.
- rd_busy[i] = (rd_addr[i]!=0) && (cnt[rd_addr[i]] > hits(rd_addr[i])).
- issue_ready = !rst && !flush && (issue_rd==0 || cnt[issue_rd] != 2^CNTW-1).
- A request to reserve x0 is accepted and has no effect.
- Counter update on each edge, when not in reset and flush==0:
  - cnt[a] <= cnt[a] + (issue_valid && issue_ready && issue_rd==a) − hits(a).
  - Simultaneous issue and write to the same register gives a net change with no glitch.
  - Decrementing below 0 is a usage error. The counter saturates at 0; the bench checks for this with an assertion.
- Flush:
  - Every cnt is cleared to 0 on the next edge.
  - Writes presented in the flush cycle still commit to rf.
  - An issue in the flush cycle is ignored, since issue_ready = 0.
- WAW: a second issue to a pending register increments cnt. rd_busy clears only when every outstanding write has returned.
- Latency: a reservation is visible through rd_busy from the cycle after issue. Write data is visible in the same cycle through bypass, and through the array from the next cycle.

Decomposition:
- A shared package holds:
  - Default XLEN, NREGS, AW, CNTW.
  - Function clog2.
  - CSR and register index constants (X0 = 0).
- One natural sub-module, regfile_wr_merge: combinational per-address hit count and priority data selection across NW ports. It is instantiated once and shared by the read bypass and commit logic.
- The counter array and read muxes stay in the top level.

Test Plan:
- Reset then read: assert rst 2 cycles, then read x5 and x31 on both ports -> rd_data = 0, rd_busy = 0, issue_ready = 1.
- Bypass: wr_en=01, wr_addr0=7, wr_data0=0xDEAD_BEEF; rd_addr0=7 in the same cycle -> rd_data0 = 0xDEAD_BEEF that cycle and from the array next cycle. A write to x0 of 0x1234 -> reading x0 returns 0.
- Write priority: both ports write x3 (port0 0x11, port1 0x22) in the same cycle -> rd_data = 0x22 during that cycle and after.
- Scoreboard WAW:
  - Issue x9 twice in consecutive cycles -> rd_busy=1.
  - One write to x9 -> rd_busy stays 1.
  - Second write -> rd_busy = 0 in that same cycle.
  - Issue x9 and write x9 in the same cycle with cnt=1 -> cnt stays 1.
- Saturation: with CNTW=2, issue x4 three times -> issue_ready for x4 = 0, while an issue to x6 is accepted.
- Flush: x2 pending (cnt=2); flush plus issue x8 plus write x2=0x55 in one cycle -> next cycle rd_busy(x2) = 0, rd_busy(x8) = 0, rf[x2] = 0x55.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults, helpers and register index constants for the integer register file.
package regfile_scoreboard_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned CNTW_DEF  = 2;

    // Architectural register indices
    localparam int unsigned X0 = 0;
    localparam int unsigned X1 = 1;
    localparam int unsigned X2 = 2;

    // CSR addresses referenced alongside the register file
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MHARTID = 12'hF14;

    // Ceiling log2; returns 0 for inputs of 0 or 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Per-address merge of the write ports: hit count and highest-index winning data.
module regfile_wr_merge
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned NW    = 2,
    parameter int unsigned HW    = clog2(NW + 1)
) (
    input  logic [NW-1:0]      wr_en_i,
    input  logic [NW*AW-1:0]   wr_addr_i,
    input  logic [NW*XLEN-1:0] wr_data_i,
    output logic [HW-1:0]      hits_o [NREGS],
    output logic [XLEN-1:0]    data_o [NREGS]
);

    // Count hits per address; later (higher-index) ports overwrite the selected data
    always_comb begin
        for (int unsigned a = 0; a < NREGS; a++) begin
            hits_o[a] = '0;
            data_o[a] = '0;
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(a)) && (a != X0)) begin
                    hits_o[a] = hits_o[a] + HW'(1);
                    data_o[a] = wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write bypass and per-register outstanding-write counters.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned NR    = 2,
    parameter int unsigned NW    = 2,
    parameter int unsigned CNTW  = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR*AW-1:0]     rd_addr_i,
    output logic [NR*XLEN-1:0]   rd_data_o,
    output logic [NR-1:0]        rd_busy_o,
    input  logic                 issue_valid_i,
    input  logic [AW-1:0]        issue_rd_i,
    output logic                 issue_ready_o,
    input  logic [NW-1:0]        wr_en_i,
    input  logic [NW*AW-1:0]     wr_addr_i,
    input  logic [NW*XLEN-1:0]   wr_data_i,
    input  logic                 flush_i
);

    localparam int unsigned HW = clog2(NW + 1);
    // Wide enough for cnt+1 and for any hit count, so compares never wrap
    localparam int unsigned SW = ((CNTW > HW) ? CNTW : HW) + 1;
    localparam logic [CNTW-1:0] CntMax = '1;

    logic [XLEN-1:0] rf_q  [NREGS];
    logic [XLEN-1:0] rf_d  [NREGS];
    logic [CNTW-1:0] cnt_q [NREGS];
    logic [CNTW-1:0] cnt_d [NREGS];
    logic [HW-1:0]   hits  [NREGS];
    logic [XLEN-1:0] win_data [NREGS];
    logic [AW-1:0]   rd_idx [NR];
    logic            issue_take;

    regfile_wr_merge #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW),
        .NW    (NW),
        .HW    (HW)
    ) u_wr_merge (
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .hits_o    (hits),
        .data_o    (win_data)
    );

    // Reservation handshake; x0 is accepted but never counted
    always_comb begin
        issue_ready_o = !rst && !flush_i &&
                        ((issue_rd_i == AW'(X0)) || (cnt_q[issue_rd_i] != CntMax));
        issue_take    = issue_valid_i && issue_ready_o && (issue_rd_i != AW'(X0));
    end

    // Read ports: bypass same-cycle writes, busy if writes remain after this cycle's returns
    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            rd_idx[i]                 = rd_addr_i[i*AW +: AW];
            rd_data_o[i*XLEN +: XLEN] = '0;
            rd_busy_o[i]              = 1'b0;
            if (rd_idx[i] != AW'(X0)) begin
                if (!rst && (hits[rd_idx[i]] != '0)) begin
                    rd_data_o[i*XLEN +: XLEN] = win_data[rd_idx[i]];
                end else begin
                    rd_data_o[i*XLEN +: XLEN] = rf_q[rd_idx[i]];
                end
                rd_busy_o[i] = !rst && (SW'(cnt_q[rd_idx[i]]) > SW'(hits[rd_idx[i]]));
            end
        end
    end

    // Next state: commit merged writes, net counter change saturating at zero
    always_comb begin
        for (int unsigned a = 0; a < NREGS; a++) begin
            rf_d[a]  = rf_q[a];
            cnt_d[a] = cnt_q[a];
            if (hits[a] != '0) begin
                rf_d[a] = win_data[a];
            end
            if (flush_i) begin
                cnt_d[a] = '0;
            end else if (SW'(cnt_q[a]) + SW'(issue_take && (issue_rd_i == AW'(a)))
                         > SW'(hits[a])) begin
                cnt_d[a] = CNTW'(SW'(cnt_q[a]) + SW'(issue_take && (issue_rd_i == AW'(a)))
                                 - SW'(hits[a]));
            end else begin
                cnt_d[a] = '0;
            end
        end
    end

    // Array and counter state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                rf_q[a]  <= '0;
                cnt_q[a] <= '0;
            end
        end else begin
            rf_q  <= rf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: cycle vectors queued as expectations, compared mid-cycle.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam logic [3:0]  ALL  = 4'hF;

    logic                clk;
    logic                rst;
    logic [2*AW-1:0]     rd_addr;
    logic [2*XLEN-1:0]   rd_data;
    logic [1:0]          rd_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                flush;

    regfile_scoreboard #(
        .XLEN  (64),
        .NREGS (32),
        .AW    (5),
        .NR    (2),
        .NW    (2),
        .CNTW  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .flush_i       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        fl;
        logic        iv;
        logic [4:0]  ird;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [3:0]  chk;
        logic [63:0] ed0;
        logic [63:0] ed1;
        logic [1:0]  eb;
        logic        er;
    } vec_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mkv(input string name, input logic r, input logic fl, input logic iv,
                                 input logic [4:0] ird, input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [63:0] wd0,
                                 input logic [4:0] wa1, input logic [63:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic [3:0] chk, input logic [63:0] ed0,
                                 input logic [63:0] ed1, input logic [1:0] eb, input logic er);
        vec_t v;
        v.name = name; v.rst = r; v.fl = fl; v.iv = iv; v.ird = ird; v.we = we;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.ra0 = ra0; v.ra1 = ra1;
        v.chk = chk; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic cmp(input string what, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", what, act, req);
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard: output sampled with no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        if (e.chk[0]) cmp({e.name, " rd_data0"}, rd_data[63:0], e.ed0);
        if (e.chk[1]) cmp({e.name, " rd_data1"}, rd_data[127:64], e.ed1);
        if (e.chk[2]) cmp({e.name, " rd_busy"}, {62'b0, rd_busy}, {62'b0, e.eb});
        if (e.chk[3]) cmp({e.name, " issue_ready"}, {63'b0, issue_ready}, {63'b0, e.er});
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge, pass the commit edge
    task automatic step(input vec_t v);
        rst         = v.rst;
        flush       = v.fl;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        wr_en       = v.we;
        wr_addr     = {v.wa1, v.wa0};
        wr_data     = {v.wd1, v.wd0};
        rd_addr     = {v.ra1, v.ra0};
        exp_q.push_back(v);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string name, input logic r, input logic fl, input logic iv,
                       input logic [4:0] ird, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [63:0] wd0,
                       input logic [4:0] wa1, input logic [63:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [3:0] chk, input logic [63:0] ed0,
                       input logic [63:0] ed1, input logic [1:0] eb, input logic er);
        step(mkv(name, r, fl, iv, ird, we, wa0, wd0, wa1, wd1, ra0, ra1, chk, ed0, ed1, eb, er));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        //                name            rst fl iv ird we     wa0 wd0           wa1 wd1    ra0 ra1 chk ed0           ed1           eb     er
        tbl.push_back(mkv("rst_wr_drop",  1, 0, 0, 0, 2'b01, 5, 64'hAA,       0, 0,      5, 31, ALL, 0,            0,            2'b00, 0));
        tbl.push_back(mkv("post_reset",   0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      5, 31, ALL, 0,            0,            2'b00, 1));
        tbl.push_back(mkv("bypass",       0, 0, 0, 0, 2'b01, 7, 64'hDEADBEEF, 0, 0,      7, 0,  ALL, 64'hDEADBEEF, 0,            2'b00, 1));
        tbl.push_back(mkv("array_x7",     0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      7, 7,  ALL, 64'hDEADBEEF, 64'hDEADBEEF, 2'b00, 1));
        tbl.push_back(mkv("wr_x0",        0, 0, 0, 0, 2'b10, 0, 0,            0, 64'h1234, 0, 0, ALL, 0,            0,            2'b00, 1));
        tbl.push_back(mkv("rd_x0",        0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      0, 7,  ALL, 0,            64'hDEADBEEF, 2'b00, 1));
        tbl.push_back(mkv("prio_same",    0, 0, 0, 0, 2'b11, 3, 64'h11,       3, 64'h22, 3, 3,  ALL, 64'h22,       64'h22,       2'b00, 1));
        tbl.push_back(mkv("prio_array",   0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      3, 3,  ALL, 64'h22,       64'h22,       2'b00, 1));
        tbl.push_back(mkv("waw_iss1",     0, 0, 1, 9, 2'b00, 0, 0,            0, 0,      9, 9,  ALL, 0,            0,            2'b00, 1));
        tbl.push_back(mkv("waw_iss2",     0, 0, 1, 9, 2'b00, 0, 0,            0, 0,      9, 9,  ALL, 0,            0,            2'b11, 1));
        tbl.push_back(mkv("waw_wr1",      0, 0, 0, 0, 2'b01, 9, 64'h99,       0, 0,      9, 9,  ALL, 64'h99,       64'h99,       2'b11, 1));
        tbl.push_back(mkv("waw_wr2",      0, 0, 0, 0, 2'b10, 0, 0,            9, 64'h9A, 9, 9,  ALL, 64'h9A,       64'h9A,       2'b00, 1));
        tbl.push_back(mkv("iss_cnt1",     0, 0, 1, 9, 2'b00, 0, 0,            0, 0,      9, 9,  ALL, 64'h9A,       64'h9A,       2'b00, 1));
        tbl.push_back(mkv("iss_and_wr",   0, 0, 1, 9, 2'b01, 9, 64'h9B,       0, 0,      9, 9,  ALL, 64'h9B,       64'h9B,       2'b00, 1));
        tbl.push_back(mkv("net_zero",     0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      9, 9,  ALL, 64'h9B,       64'h9B,       2'b11, 1));
        tbl.push_back(mkv("drain9",       0, 0, 0, 0, 2'b01, 9, 64'h9C,       0, 0,      9, 9,  ALL, 64'h9C,       64'h9C,       2'b00, 1));
        tbl.push_back(mkv("idle9",        0, 0, 0, 0, 2'b00, 0, 0,            0, 0,      9, 9,  ALL, 64'h9C,       64'h9C,       2'b00, 1));

        @(posedge clk);
        #1;
        for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

        // Underflow: two writes to an unreserved register must leave its counter at zero
        cyc("uf_wr2",   0, 0, 0, 0,  2'b11, 12, 64'h1, 12, 64'h2, 12, 0,  ALL, 64'h2, 0,     2'b00, 1);
        cyc("uf_sat",   0, 0, 0, 0,  2'b00, 0,  0,     0,  0,     12, 12, ALL, 64'h2, 64'h2, 2'b00, 1);
        assert (rd_busy == 2'b00) else $error("FAIL uf_assert: counter wrapped below zero");
        cyc("uf_iss",   0, 0, 1, 12, 2'b00, 0,  0,     0,  0,     12, 0,  ALL, 64'h2, 0,     2'b00, 1);
        cyc("uf_wr",    0, 0, 0, 0,  2'b01, 12, 64'h3, 0,  0,     12, 12, ALL, 64'h3, 64'h3, 2'b00, 1);

        // Saturation at 2^CNTW-1 pending writes
        cyc("sat_i1",   0, 0, 1, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b00, 1);
        cyc("sat_i2",   0, 0, 1, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b01, 1);
        cyc("sat_i3",   0, 0, 1, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b01, 1);
        cyc("sat_full", 0, 0, 1, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b01, 0);
        cyc("sat_x6",   0, 0, 1, 6, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b01, 1);
        cyc("sat_chk",  0, 0, 0, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 0,      0,      2'b11, 0);
        cyc("sat_dual", 0, 0, 0, 0, 2'b11, 4, 64'h41, 4, 64'h42, 4, 6, ALL, 64'h42, 0,      2'b11, 1);
        cyc("sat_last", 0, 0, 0, 0, 2'b11, 4, 64'h43, 6, 64'h66, 4, 6, ALL, 64'h43, 64'h66, 2'b00, 1);
        cyc("sat_done", 0, 0, 0, 4, 2'b00, 0, 0,      0, 0,      4, 6, ALL, 64'h43, 64'h66, 2'b00, 1);

        // Flush drops reservations, still commits writes, ignores the same-cycle issue
        cyc("fl_i1",    0, 0, 1, 2, 2'b00, 0, 0,      0, 0,      2, 8, ALL, 0,      0,      2'b00, 1);
        cyc("fl_i2",    0, 0, 1, 2, 2'b00, 0, 0,      0, 0,      2, 8, ALL, 0,      0,      2'b01, 1);
        cyc("fl_cyc",   0, 1, 1, 8, 2'b01, 2, 64'h55, 0, 0,      2, 8, ALL, 64'h55, 0,      2'b01, 0);
        cyc("fl_after", 0, 0, 0, 8, 2'b00, 0, 0,      0, 0,      2, 8, ALL, 64'h55, 0,      2'b00, 1);
        cyc("fl_reiss", 0, 0, 1, 8, 2'b00, 0, 0,      0, 0,      2, 8, ALL, 64'h55, 0,      2'b00, 1);
        cyc("fl_busy8", 0, 0, 0, 0, 2'b00, 0, 0,      0, 0,      2, 8, ALL, 64'h55, 0,      2'b10, 1);
        cyc("fl_wr8",   0, 0, 0, 0, 2'b10, 0, 0,      8, 64'h88, 2, 8, ALL, 64'h55, 64'h88, 2'b00, 1);

        // Reset in mid-run: array-only reads, no busy, no ready, then everything cleared
        cyc("pre_rst",  0, 0, 1, 8, 2'b00, 0, 0,      0, 0,      3, 8, ALL, 64'h22, 64'h88, 2'b00, 1);
        cyc("rst_mid",  1, 0, 1, 3, 2'b01, 3, 64'h77, 0, 0,      3, 8, ALL, 64'h22, 64'h88, 2'b00, 0);
        cyc("rst_out",  0, 0, 0, 0, 2'b00, 0, 0,      0, 0,      3, 8, ALL, 0,      0,      2'b00, 1);

        cmp("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
